// File: rtl/bank_sequencer.sv
// Bank sequencer: tracks (zp),Y opcodes and selects the bank for each bus cycle.
// Exposes writable exec/indirect bank registers at 0x0000/0x0001.
module bank_sequencer #(
    parameter logic [3:0] EXEC_RESET = 4'hF,
    parameter logic [3:0] IND_RESET  = 4'hF
) (
    input  logic        clock,
    input  logic        _reset,
    input  logic        cycle_end,
    input  logic        phi2,
    input  logic        r_w,
    input  logic        sync,
    input  logic        rdy,
    input  logic [15:0] address_cpu,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [3:0]  address_bank,
    output logic [3:0]  exec_bank,
    output logic [3:0]  ind_bank,
    output logic        ind_active
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ZP   = 3'd1,
        S_PLO  = 3'd2,
        S_PHI  = 3'd3,
        S_D1   = 3'd4,
        S_D2   = 3'd5
    } state_t;

    localparam logic [7:0] OP_LDA_IZY = 8'hB1;
    localparam logic [7:0] OP_STA_IZY = 8'h91;

    state_t     state_q, state_d;
    logic [3:0] exec_q, exec_d;
    logic [3:0] ind_q, ind_d;

    logic step;
    logic is_indirect;
    logic wr_exec;
    logic wr_ind;
    logic rd_regs;
    logic ind_sel;

    assign step        = cycle_end & rdy;
    assign is_indirect = (data_in == OP_LDA_IZY) | (data_in == OP_STA_IZY);

    // Register writes ignore rdy: a write cycle is never stretched.
    assign wr_exec = cycle_end & ~r_w & (address_cpu == 16'h0000);
    assign wr_ind  = cycle_end & ~r_w & (address_cpu == 16'h0001);

    // Next-state decode; an opcode fetch always restarts the sequence.
    always_comb begin
        state_d = state_q;
        if (step) begin
            if (sync) begin
                state_d = is_indirect ? S_ZP : S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE:  state_d = S_IDLE;
                    S_ZP:    state_d = S_PLO;
                    S_PLO:   state_d = S_PHI;
                    S_PHI:   state_d = S_D1;
                    S_D1:    state_d = S_D2;
                    S_D2:    state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Bank register next values from CPU writes.
    always_comb begin
        exec_d = exec_q;
        ind_d  = ind_q;
        if (wr_exec) begin
            exec_d = data_in[3:0];
        end
        if (wr_ind) begin
            ind_d = data_in[3:0];
        end
    end

    // State and bank registers, cleared asynchronously.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= S_IDLE;
            exec_q  <= EXEC_RESET;
            ind_q   <= IND_RESET;
        end else begin
            state_q <= state_d;
            exec_q  <= exec_d;
            ind_q   <= ind_d;
        end
    end

    // D2 with sync high is the next opcode fetch after an uncrossed LDA.
    always_comb begin
        ind_sel = 1'b0;
        if (state_q == S_D1) begin
            ind_sel = 1'b1;
        end else if ((state_q == S_D2) && !sync) begin
            ind_sel = 1'b1;
        end
    end

    // Readback of the bank registers, live even while in reset.
    always_comb begin
        rd_regs  = r_w & phi2 & (address_cpu[15:1] == 15'd0);
        data_out = 8'h00;
        if (rd_regs) begin
            data_out = {4'hF, address_cpu[0] ? ind_q : exec_q};
        end
    end

    assign data_oe      = rd_regs;
    assign ind_active   = ind_sel;
    assign address_bank = ind_sel ? ind_q : exec_q;
    assign exec_bank    = exec_q;
    assign ind_bank     = ind_q;

endmodule
